// File: rtl/add_sub_pipe_if.sv
// add_sub_pipe_if: operand/result valid-ready bundle between the register-read latches and the ALU mux.
interface add_sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid, in_ready, cin, sub, sat;
  logic             out_valid, out_ready, cout, ovf, zero;
  logic [WIDTH-1:0] a, b, z;
  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, z, cout, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, z, cout, ovf, zero
  );
endinterface

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: STAGES-deep valid/ready adder/subtractor, one slice of 4-bit CLA groups per stage.
// Define ADD_SAT_EN to build signed saturation, applied when the beat's sat bit is set.
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic           clock,
  input logic           clear,
  add_sub_pipe_if.slave s
);
  localparam int SW = WIDTH / STAGES;
  logic w_adv, w_out_v;
  assign w_adv      = ~w_out_v | s.out_ready;
  assign s.in_ready = w_adv;
  // Lookahead inside each 4-bit group; group carries ripple across the slice.
  function automatic logic [SW:0] cla(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] p, g;
    logic [SW:0]   c;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < SW; j += 4) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j]) | (p[j+2] & p[j+1] & p[j] & c[j]);
      c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1]) | (p[j+3] & p[j+2] & p[j+1] & g[j])
             | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
    end
    return {c[SW], p ^ c[SW-1:0]};
  endfunction
  for (genvar k = 0; k < STAGES; k++) begin : gen_s
    localparam int SRCW = WIDTH - k * SW;
    localparam int ZW   = (k + 1) * SW;
    logic [SRCW-1:0] w_a, w_b;
    logic [ZW-1:0]   w_zr, w_z, r_z;
    logic [SW:0]     w_r;
    logic            w_ci, w_vi, r_v, r_c;
`ifdef ADD_SAT_EN
    logic            w_si;
`endif
    if (k == 0) begin : g_src
      assign w_a  = s.a;
      assign w_b  = s.sub ? ~s.b : s.b;
      assign w_ci = s.sub | s.cin;
      assign w_vi = s.in_valid;
      assign w_zr = w_r[SW-1:0];
`ifdef ADD_SAT_EN
      assign w_si = s.sat;
`endif
    end else begin : g_src
      // Upper operand slices arrive skewed; finished lower result slices ride alongside.
      assign w_a  = gen_s[k-1].g_nxt.r_a;
      assign w_b  = gen_s[k-1].g_nxt.r_b;
      assign w_ci = gen_s[k-1].r_c;
      assign w_vi = gen_s[k-1].r_v;
      assign w_zr = {w_r[SW-1:0], gen_s[k-1].r_z};
`ifdef ADD_SAT_EN
      assign w_si = gen_s[k-1].g_nxt.r_sat;
`endif
    end
    assign w_r = cla(w_a[SW-1:0], w_b[SW-1:0], w_ci);
    always_ff @(posedge clock or negedge clear)
      if (!clear) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_z <= '0;
      end else if (w_adv) begin
        r_v <= w_vi;
        r_c <= w_r[SW];
        r_z <= w_z;
      end
    if (k == STAGES - 1) begin : g_nxt
      logic w_ovf, r_ovf, r_zero;
      assign w_ovf = (w_a[SW-1] == w_b[SW-1]) & (w_r[SW-1] != w_a[SW-1]);
`ifdef ADD_SAT_EN
      assign w_z = (w_si & w_ovf) ? {w_a[SW-1], {(WIDTH-1){~w_a[SW-1]}}} : w_zr;
`else
      assign w_z = w_zr;
`endif
      always_ff @(posedge clock or negedge clear)
        if (!clear) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_ovf  <= w_ovf;
          r_zero <= ~|w_z;
        end
      assign w_out_v     = r_v;
      assign s.out_valid = r_v;
      assign s.z         = r_z;
      assign s.cout      = r_c;
      assign s.ovf       = r_ovf;
      assign s.zero      = r_zero;
    end else begin : g_nxt
      logic [SRCW-SW-1:0] r_a, r_b;
      assign w_z = w_zr;
      always_ff @(posedge clock)
        if (w_adv) begin
          r_a <= w_a[SRCW-1:SW];
          r_b <= w_b[SRCW-1:SW];
        end
`ifdef ADD_SAT_EN
      logic r_sat;
      always_ff @(posedge clock)
        if (w_adv) r_sat <= w_si;
`endif
    end
  end
endmodule
